// File: rtl/matmul_sched.sv
// matmul_sched: round-robin job scheduler sharing one N x N matrix-multiply engine
// among R requesters. Operands are latched on accept and held on the engine
// through RUN; the result (or a timeout abort) is returned in RESP, and a
// FLUSH cycle guarantees the engine sees en low long enough to clear.
module matmul_sched #(
    parameter int unsigned W       = 32,
    parameter int unsigned N       = 3,
    parameter int unsigned R       = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [R-1:0]           i_req_valid,
    output logic [R-1:0]           o_req_ready,
    input  logic [R*W*N*N-1:0]     i_req_A,
    input  logic [R*W*N*N-1:0]     i_req_B,
    input  logic [R-1:0]           i_req_mode,
    output logic [R-1:0]           o_rsp_valid,
    input  logic [R-1:0]           i_rsp_ready,
    output logic [W*N*N-1:0]       o_rsp_C,
    output logic                   o_rsp_err,
    output logic [$clog2(R)-1:0]   o_grant_id,
    output logic                   o_busy,
    output logic                   o_eng_en,
    output logic                   o_eng_mode,
    output logic [W*N*N-1:0]       o_eng_A,
    output logic [W*N*N-1:0]       o_eng_B,
    input  logic [W*N*N-1:0]       i_eng_C,
    input  logic                   i_eng_done
);

    localparam int unsigned M  = W * N * N;
    localparam int unsigned GW = $clog2(R);
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StResp,
        StFlush
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [M-1:0]    eng_a_q, eng_a_d;
    logic [M-1:0]    eng_b_q, eng_b_d;
    logic            eng_mode_q, eng_mode_d;
    logic [M-1:0]    rsp_c_q, rsp_c_d;
    logic            rsp_err_q, rsp_err_d;

    logic [2*R-1:0]  req_dbl;
    logic [R-1:0]    req_rot;
    logic            win_found;
    logic [GW-1:0]   win_off;
    logic [GW:0]     win_sum;
    logic [GW-1:0]   win_idx;

    // Round-robin winner: rotate requests so ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        req_dbl   = {i_req_valid, i_req_valid};
        req_rot   = req_dbl[ptr_q +: R];
        win_found = 1'b0;
        win_off   = '0;
        for (int i = int'(R) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_found = 1'b1;
                win_off   = GW'(i);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= (GW+1)'(R)) begin
            win_sum = win_sum - (GW+1)'(R);
        end
        win_idx = win_sum[GW-1:0];
    end

    // Next-state, datapath capture and handshake outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        eng_a_d     = eng_a_q;
        eng_b_d     = eng_b_q;
        eng_mode_d  = eng_mode_q;
        rsp_c_d     = rsp_c_q;
        rsp_err_d   = rsp_err_q;
        o_eng_en    = 1'b0;
        o_req_ready = '0;
        o_rsp_valid = '0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    o_req_ready[win_idx] = 1'b1;
                    eng_a_d    = i_req_A[win_idx*M +: M];
                    eng_b_d    = i_req_B[win_idx*M +: M];
                    eng_mode_d = i_req_mode[win_idx];
                    grant_d    = win_idx;
                    ptr_d      = (win_idx == GW'(R - 1)) ? '0 : win_idx + 1'b1;
                    cnt_d      = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                o_eng_en = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                // Done takes priority over a coincident timeout.
                if (i_eng_done) begin
                    rsp_c_d   = i_eng_C;
                    rsp_err_d = 1'b0;
                    state_d   = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_c_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                o_rsp_valid[grant_q] = 1'b1;
                if (i_rsp_ready[grant_q]) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight job.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            eng_a_q    <= '0;
            eng_b_q    <= '0;
            eng_mode_q <= 1'b0;
            rsp_c_q    <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            eng_a_q    <= eng_a_d;
            eng_b_q    <= eng_b_d;
            eng_mode_q <= eng_mode_d;
            rsp_c_q    <= rsp_c_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign o_busy     = (state_q != StIdle);
    assign o_grant_id = grant_q;
    assign o_eng_A    = eng_a_q;
    assign o_eng_B    = eng_b_q;
    assign o_eng_mode = eng_mode_q;
    assign o_rsp_C    = rsp_c_q;
    assign o_rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_matmul_sched.sv
// tb_matmul_sched: directed tests with a result scoreboard. Expected results are
// pushed when a job is accepted and popped on each response handshake.
module tb_matmul_sched;

    localparam int W       = 32;
    localparam int N       = 3;
    localparam int R       = 4;
    localparam int TIMEOUT = 32;
    localparam int M       = W * N * N;

    typedef struct {
        int           id;
        logic [M-1:0] c;
        logic         err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [R-1:0]     req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
    logic [R*M-1:0]   req_A, req_B;
    logic [M-1:0]     rsp_C, eng_A, eng_B, eng_C;
    logic             rsp_err, busy, eng_en, eng_mode, eng_done;
    logic [1:0]       grant_id;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_at  = 0;   // engine raises done on this en cycle; 0 = never
    int   en_cnt;
    exp_t sb[$];

    always #5 clk = ~clk;

    matmul_sched #(.W(W), .N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_A     (req_A),
        .i_req_B     (req_B),
        .i_req_mode  (req_mode),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_C     (rsp_C),
        .o_rsp_err   (rsp_err),
        .o_grant_id  (grant_id),
        .o_busy      (busy),
        .o_eng_en    (eng_en),
        .o_eng_mode  (eng_mode),
        .o_eng_A     (eng_A),
        .o_eng_B     (eng_B),
        .i_eng_C     (eng_C),
        .i_eng_done  (eng_done)
    );

    // Engine model: mode 0 multiplies, mode 1 adds element-wise.
    function automatic logic [M-1:0] mat_op(input logic [M-1:0] a, input logic [M-1:0] b,
                                            input logic mode);
        logic [M-1:0] c;
        logic [W-1:0] acc;
        c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (mode) begin
                    acc = a[(i*N+j)*W +: W] + b[(i*N+j)*W +: W];
                end else begin
                    acc = '0;
                    for (int k = 0; k < N; k++) begin
                        acc = acc + a[(i*N+k)*W +: W] * b[(k*N+j)*W +: W];
                    end
                end
                c[(i*N+j)*W +: W] = acc;
            end
        end
        return c;
    endfunction

    // Engine model: count en cycles, clear when en drops.
    always @(posedge clk or posedge rst) begin
        if (rst) en_cnt <= 0;
        else if (eng_en) en_cnt <= en_cnt + 1;
        else en_cnt <= 0;
    end
    assign eng_done = eng_en && (done_at > 0) && (en_cnt == done_at - 1);
    assign eng_C    = mat_op(eng_A, eng_B, eng_mode);

    task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard push on accept, pop on response handshake, plus handshake invariants.
    always @(negedge clk) begin : mon
        exp_t e;
        int   id;
        if (rst) begin
            sb.delete();
        end else begin
            if (req_ready != 0 || rsp_valid != 0) begin
                check("rdy_rsp_excl", M'((|req_ready) & (|rsp_valid)), M'(1'b0));
                check("rdy_onehot", M'($countones(req_ready) > 1), M'(1'b0));
            end
            if ((req_valid & req_ready) != 0) begin
                id = 0;
                for (int r = 0; r < R; r++) if (req_ready[r]) id = r;
                e.id  = id;
                e.err = (done_at == 0) || (done_at > TIMEOUT);
                e.c   = e.err ? '0 : mat_op(req_A[id*M +: M], req_B[id*M +: M], req_mode[id]);
                sb.push_back(e);
            end
            if ((rsp_valid & rsp_ready) != 0) begin
                id = 0;
                for (int r = 0; r < R; r++) if (rsp_valid[r]) id = r;
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", M'(1'b1), M'(1'b0));
                end else begin
                    e = sb.pop_front();
                    check("sb_id", M'(id), M'(e.id));
                    check("sb_C", rsp_C, e.c);
                    check("sb_err", M'(rsp_err), M'(e.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int r, input logic [M-1:0] a, input logic [M-1:0] b,
                           input logic mode);
        req_A[r*M +: M] = a;
        req_B[r*M +: M] = b;
        req_mode[r]     = mode;
    endtask

    function automatic logic [M-1:0] rand_mat();
        logic [M-1:0] m;
        for (int k = 0; k < N*N; k++) m[k*W +: W] = W'($urandom_range(0, 999));
        return m;
    endfunction

    // Wait for a response, counting en-high cycles seen on the way.
    task automatic wait_rsp(output int en_cycles, output bit ok);
        en_cycles = 0;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid != 0) begin
                ok = 1'b1;
                break;
            end
            if (eng_en) en_cycles++;
            tick();
        end
    endtask

    // Submit one job on requester r, wait for its response, complete the handshake.
    task automatic run_job(input int r, input string tag, output int en_c);
        bit ok;
        logic [M-1:0] a, b;
        logic mode;
        a    = rand_mat();
        b    = rand_mat();
        mode = 1'($urandom_range(0, 1));
        set_job(r, a, b, mode);
        rsp_ready = '1;
        req_valid = R'(1) << r;
        tick();
        req_valid = '0;
        wait_rsp(en_c, ok);
        check({tag, "_rsp_seen"}, M'(ok), M'(1'b1));
        check({tag, "_rsp_valid"}, M'(rsp_valid), M'(R'(1) << r));
        tick();
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [M-1:0] ident, seq, c0;
        int  en_c;
        bit  ok, seen;
        int  exp_order[5];

        rst = 1'b1; req_valid = '0; req_A = '0; req_B = '0; req_mode = '0; rsp_ready = '0;
        tick();
        tick();
        // Reset values
        check("rst_busy", M'(busy), M'(1'b0));
        check("rst_en", M'(eng_en), M'(1'b0));
        check("rst_grant", M'(grant_id), M'(0));
        check("rst_engA", eng_A, '0);
        check("rst_rspC", rsp_C, '0);
        check("rst_err", M'(rsp_err), M'(1'b0));
        check("rst_ready", M'(req_ready), M'(0));
        check("rst_rsp_valid", M'(rsp_valid), M'(0));
        rst = 1'b0;
        tick();

        // Single job on requester 2: A = identity, B = 1..9
        ident = '0;
        seq   = '0;
        for (int i = 0; i < N; i++) ident[(i*N+i)*W +: W] = W'(1);
        for (int k = 0; k < N*N; k++) seq[k*W +: W] = W'(k + 1);
        done_at   = 7;
        rsp_ready = '1;
        set_job(2, ident, seq, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("id_ready", M'(req_ready), M'(4'b0100));
        tick();
        req_valid = '0;
        check("id_en_after_accept", M'(eng_en), M'(1'b1));
        check("id_busy_after_accept", M'(busy), M'(1'b1));
        check("id_grant", M'(grant_id), M'(2));
        check("id_engB", eng_B, seq);
        wait_rsp(en_c, ok);
        check("id_rsp_seen", M'(ok), M'(1'b1));
        check("id_en_cycles", M'(en_c), M'(7));
        check("id_rsp_valid", M'(rsp_valid), M'(4'b0100));
        check("id_rsp_C", rsp_C, seq);
        check("id_err", M'(rsp_err), M'(1'b0));
        check("id_resp_en", M'(eng_en), M'(1'b0));
        tick();
        check("id_flush_busy", M'(busy), M'(1'b1));
        check("id_flush_en", M'(eng_en), M'(1'b0));
        tick();
        check("id_idle_busy", M'(busy), M'(1'b0));

        // Pointer is 3 after granting 2: requesters 0 and 3 race, 3 wins
        done_at = 3;
        set_job(0, rand_mat(), rand_mat(), 1'b0);
        set_job(3, rand_mat(), rand_mat(), 1'b1);
        req_valid = 4'b1001;
        #1;
        check("ptr_ready", M'(req_ready), M'(4'b1000));
        tick();
        req_valid = 4'b0001;
        check("ptr_busy_ready", M'(req_ready), M'(0));
        wait_rsp(en_c, ok);
        check("ptr_rsp_seen", M'(ok), M'(1'b1));
        tick();
        check("ptr_flush_ready", M'(req_ready), M'(0));
        tick();
        check("ptr_next_ready", M'(req_ready), M'(4'b0001));
        tick();
        req_valid = '0;
        wait_rsp(en_c, ok);
        check("ptr2_rsp_valid", M'(rsp_valid), M'(4'b0001));
        tick();
        tick();

        // Response backpressure: owner 1 stalls while requester 0 is ready
        done_at = 4;
        set_job(1, rand_mat(), rand_mat(), 1'b0);
        set_job(3, rand_mat(), rand_mat(), 1'b0);
        rsp_ready = 4'b0001;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1000;
        wait_rsp(en_c, ok);
        check("bp_rsp_seen", M'(ok), M'(1'b1));
        c0 = rsp_C;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", M'(rsp_valid), M'(4'b0010));
            check("bp_rsp_C_stable", rsp_C, c0);
            check("bp_en", M'(eng_en), M'(1'b0));
            check("bp_ready", M'(req_ready), M'(0));
            tick();
        end
        check("bp_still_valid", M'(rsp_valid), M'(4'b0010));
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = '1;
        check("bp_flush_valid", M'(rsp_valid), M'(0));
        tick();
        check("bp_next_ready", M'(req_ready), M'(4'b1000));
        tick();
        req_valid = '0;
        wait_rsp(en_c, ok);
        check("bp_next_rsp", M'(rsp_valid), M'(4'b1000));
        tick();
        tick();

        // Timeout: engine never finishes
        done_at = 0;
        set_job(0, rand_mat(), rand_mat(), 1'b0);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        wait_rsp(en_c, ok);
        check("to_rsp_seen", M'(ok), M'(1'b1));
        check("to_en_cycles", M'(en_c), M'(TIMEOUT));
        check("to_err", M'(rsp_err), M'(1'b1));
        check("to_C", rsp_C, '0);
        tick();
        tick();
        done_at = 5;
        run_job(1, "to_resume", en_c);
        check("to_resume_en", M'(en_c), M'(5));

        // Done coincides with last timeout cycle: done wins
        done_at = TIMEOUT;
        run_job(3, "both", en_c);
        check("both_en_cycles", M'(en_c), M'(TIMEOUT));
        check("both_err", M'(rsp_err), M'(1'b0));
        check("both_C", rsp_C, mat_op(req_A[3*M +: M], req_B[3*M +: M], req_mode[3]));

        // Reset asynchronously in the middle of RUN
        done_at = 10;
        set_job(2, rand_mat(), rand_mat(), 1'b0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("mr_en", M'(eng_en), M'(1'b0));
        check("mr_busy", M'(busy), M'(1'b0));
        check("mr_grant", M'(grant_id), M'(0));
        check("mr_engA", eng_A, '0);
        check("mr_rspC", rsp_C, '0);
        check("mr_rsp_valid", M'(rsp_valid), M'(0));
        @(posedge clk);
        #3;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid != 0) seen = 1'b1;
        end
        check("mr_no_rsp", M'(seen), M'(1'b0));
        done_at = 3;
        run_job(1, "mr_after", en_c);
        check("mr_after_en", M'(en_c), M'(3));

        // Fairness: all four hold valid from reset
        rst = 1'b1;
        done_at = 2;
        for (int r = 0; r < R; r++) set_job(r, rand_mat(), rand_mat(), 1'($urandom_range(0, 1)));
        req_valid = '1;
        rsp_ready = '1;
        tick();
        rst = 1'b0;
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (req_ready != 0) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            check("fair_ready_seen", M'(ok), M'(1'b1));
            check("fair_ready", M'(req_ready), M'(R'(1) << exp_order[k]));
            tick();
            check("fair_grant", M'(grant_id), M'(exp_order[k]));
        end
        req_valid = '0;
        for (int i = 0; i < 50 && busy; i++) tick();
        check("fair_idle", M'(busy), M'(1'b0));

        tick();
        check("sb_drain", M'(sb.size()), M'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
